// File: rtl/riscv_pkg.sv
// RV32I opcode constants, encoder format enum and FIFO payload type shared by the encoder files.
package riscv_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } enc_fmt_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               err;
    } enc_word_t;

    // Opcode to instruction format; anything outside RV32I base subset is FMT_BAD.
    function automatic enc_fmt_t opc_fmt(input logic [OPC_W-1:0] op);
        enc_fmt_t f;
        case (op)
            OPC_LOAD, OPC_OPIMM: f = FMT_I;
            OPC_STORE:           f = FMT_S;
            OPC_OP:              f = FMT_R;
            OPC_LUI, OPC_AUIPC:  f = FMT_U;
            OPC_BRANCH:          f = FMT_B;
            OPC_JAL:             f = FMT_J;
            default:             f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous valid/ready FIFO with synchronous flush; read data forced to zero while empty.
module enc_fifo #(
    parameter int unsigned W     = 43,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign rd_valid = (count != '0);
    // A full FIFO may still take a word when the head leaves in the same cycle.
    assign wr_ready = !clr && (!full || rd_ready);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready && !clr;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field packer feeding an output FIFO, with IMEM address tagging and a word counter.
// Optional ENC_RANGE_CHECK_EN: also flag immediates that do not fit their format.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned nbits     = 32,
    parameter int unsigned AW        = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic [nbits-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [AW-1:0]    out_addr,
    output logic             out_err,
    output logic [15:0]      word_cnt
);

    localparam int unsigned FW = INSTR_W + 1 + AW;

    enc_fmt_t       fmt;
    logic [31:0]    word;
    logic           err;
    logic           accept;
    logic           imm12_bad;
    logic           imm20_bad;
    logic           immu_bad;
    logic [AW-1:0]  addr;
    logic [FW-1:0]  wr_data;
    logic [FW-1:0]  rd_data;
    enc_word_t      wr_word;
    enc_word_t      rd_word;

`ifdef ENC_RANGE_CHECK_EN
    assign imm12_bad = !((&imm[31:11]) || !(|imm[31:11]));
    assign imm20_bad = !((&imm[31:19]) || !(|imm[31:19]));
    assign immu_bad  = |imm[11:0];
`else
    assign imm12_bad = 1'b0;
    assign imm20_bad = 1'b0;
    assign immu_bad  = 1'b0;
`endif

    // B and J immediates arrive in half-word units, so bit n here is byte-offset bit n+1.
    always_comb begin
        fmt  = opc_fmt(opcode);
        word = NOP_INSTR;
        err  = 1'b0;
        case (fmt)
            FMT_I: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                err  = imm12_bad;
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = imm12_bad;
            end
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_U: begin
                word = {imm[31:12], rd, opcode};
                err  = immu_bad;
            end
            FMT_B: begin
                word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
                err  = imm12_bad;
            end
            FMT_J: begin
                word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
                err  = imm20_bad;
            end
            default: begin
                word = NOP_INSTR;
                err  = 1'b1;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // Address and count advance on every accepted word, including illegal ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= AW'(BASE_ADDR);
            word_cnt <= '0;
        end else if (clr) begin
            addr     <= AW'(BASE_ADDR);
            word_cnt <= '0;
        end else if (accept) begin
            addr <= addr + AW'(4);
            if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
        end
    end

    assign wr_word = '{instr: word, err: err};
    assign wr_data = {wr_word, addr};

    enc_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (wr_data),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (rd_data)
    );

    assign {rd_word, out_addr} = rd_data;
    assign out_instr = rd_word.instr;
    assign out_err   = rd_word.err;

endmodule
